// File: rtl/temp_fe_pkg.sv
// Shared types and constants for the temperature sensor front end.
// Holds the receiver FSM encoding and the sample saturation helper.
package temp_fe_pkg;

  localparam int         TEMP_W     = 5;
  localparam logic [4:0] TEMP_MAX   = 5'd31;
  localparam logic [4:0] TEMP_RESET = 5'd20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } fe_state_e;

  // Readings above the controller's range pin at TEMP_MAX instead of wrapping.
  function automatic logic [TEMP_W-1:0] clamp_temp(input logic [31:0] raw);
    logic [TEMP_W-1:0] res;
    if (raw > 32'(TEMP_MAX)) begin
      res = TEMP_MAX;
    end else begin
      res = raw[TEMP_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sensor_shift_rx.sv
// Serial frame receiver: start strobe, MSB-first shift-in, abort on a repeated start.
// frame_done_o is high during the UPDATE cycle; abort_o pulses the cycle after a restart.
module sensor_shift_rx
  import temp_fe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] raw_o,
  output logic              frame_done_o,
  output logic              abort_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  fe_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-2:0] shift_q;
  logic [DATA_W-1:0] raw_q;
  logic              done_q;
  logic              abort_q;
  logic              last_bit_s;

  assign last_bit_s = (cnt_q == CNT_W'(DATA_W - 1));

  // Receiver FSM; a start seen mid-frame wins over the last data bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      raw_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (start_i) begin
            abort_q <= 1'b1;
            cnt_q   <= '0;
          end else if (last_bit_s) begin
            raw_q   <= {shift_q, bit_i};
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= UPDATE;
          end else begin
            shift_q <= {shift_q[DATA_W-3:0], bit_i};
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign raw_o        = raw_q;
  assign frame_done_o = done_q;
  assign abort_o      = abort_q;

endmodule

// File: rtl/temp_sensor_frontend.sv
// Temperature front end: clamps received readings, keeps a moving-average window,
// and reports validity, staleness and frame aborts to the thermostat controller.
module temp_sensor_frontend
  import temp_fe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_start,
  input  logic        sensor_bit,
  output logic [4:0]  temperature,
  output logic        temp_valid,
  output logic        stale,
  output logic        sensor_err
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] raw_s;
  logic              frame_done_s;
  logic              abort_s;

  logic [TEMP_W-1:0] hist_q [DEPTH];
  logic [TEMP_W-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              valid_q, valid_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              stale_q, stale_d;
  logic [TEMP_W-1:0] sample_s;
  logic [SUM_W-1:0]  sum_s;

  sensor_shift_rx #(
    .DATA_W (DATA_W)
  ) u_rx (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (sensor_start),
    .bit_i        (sensor_bit),
    .raw_o        (raw_s),
    .frame_done_o (frame_done_s),
    .abort_o      (abort_s)
  );

  // History shift, window sum and sample-count saturation on each completed frame.
  always_comb begin
    sample_s = clamp_temp(32'(raw_s));
    sum_s    = '0;
    if (frame_done_s) begin
      hist_d[0] = sample_s;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        sum_s = sum_s + SUM_W'(hist_d[i]);
      end
      temp_d = sum_s[SUM_W-1:AVG_LOG2];
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      valid_d = (count_d == CNT_W'(DEPTH));
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i];
      end
      temp_d  = temp_q;
      count_d = count_q;
      valid_d = valid_q;
    end
  end

  // Watchdog: cycles since the last completed frame, saturating at TIMEOUT.
  always_comb begin
    if (frame_done_s) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
    stale_d = (wd_d >= WD_W'(TIMEOUT));
  end

  // Output and history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= TEMP_RESET;
      end
      count_q <= '0;
      temp_q  <= TEMP_RESET;
      valid_q <= 1'b0;
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
      count_q <= count_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end

  assign temperature = temp_q;
  assign temp_valid  = valid_q;
  assign stale       = stale_q;
  assign sensor_err  = abort_s;

endmodule

// File: doc/temp_sensor_frontend.md
Name: temp_sensor_frontend

Overview:
- Upstream stage of the thermostat controller.
- Receives framed serial readings from a digital temperature sensor, converts each to a 5-bit value saturated to 0..31 °C, and smooths them with a 4-sample moving average.
- Drives the controller's 5-bit temperature input, plus valid, stale and error status.

Parameters:
- DATA_W, 8: bits per sensor frame, unsigned integer °C, MSB first.
- AVG_LOG2, 2: log2 of the averaging window (window = 4 samples).
- TIMEOUT, 1000: clock cycles without a completed frame before the output is flagged stale.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sensor_start  in  1  one-cycle frame-start strobe.
- sensor_bit  in  1  serial data bit.
- temperature  out  5  averaged temperature in °C; feeds the controller's temperature input.
- temp_valid  out  1  high once the window has been filled with real samples since reset.
- stale  out  1  no frame completed within TIMEOUT cycles.
- sensor_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values:
  - temperature = 5'd20 (inside the controller's idle band).
  - temp_valid = 0, stale = 0, sensor_err = 0.
  - All history entries = 20; sample count = 0; FSM = IDLE.
- Reset asserted mid-frame discards the partial frame.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - sensor_start=1 → SHIFT, bit count cleared.
  - sensor_bit is ignored in the start cycle.
- SHIFT:
  - Each cycle shifts sensor_bit into the receive register, MSB first.
  - After DATA_W bits → UPDATE.
  - sensor_start=1 during SHIFT aborts the frame:
    - sensor_err pulses high for exactly 1 cycle.
    - Bit count clears and the FSM stays in SHIFT (restart).
    - No history update occurs.
  - If sensor_start=1 coincides with the last data bit, the abort wins and the frame is discarded.
- UPDATE (1 cycle):
  - sample = min(raw, 31), unsigned.
  - Sample is pushed into the 4-entry history; the oldest entry is dropped.
  - sum is 7 bits; temperature = sum >> AVG_LOG2 (truncating).
  - Sample count saturates at 4; temp_valid = 1 when count reaches 4.
  - Returns to IDLE.
  - sensor_start during UPDATE is ignored.
- Latency: temperature and temp_valid change on the clock edge that ends UPDATE, i.e. 1 + DATA_W + 1 cycles after the start strobe.
- Outputs are registered and held constant between updates.
- Watchdog:
  - Counter clears on reset and on every UPDATE, increments otherwise and saturates.
  - stale = 1 once the count ≥ TIMEOUT.
  - stale clears on the next UPDATE.
  - temperature and temp_valid are unaffected by stale.

Decomposition:
- Package temp_fe_pkg:
  - TEMP_W = 5, TEMP_MAX = 31, TEMP_RESET = 20.
  - FSM state enum {IDLE, SHIFT, UPDATE}.
- Sub-module sensor_shift_rx:
  - Contains the bit counter, shift register and abort detection.
  - Outputs raw[DATA_W-1:0], frame_done (1-cycle) and abort (1-cycle).
- The top level keeps the history, averaging, watchdog and output registers.

Test Plan:
- Reset, then frames 25, 25, 25, 25 → after each UPDATE temperature = 21, 22, 23, 25; temp_valid rises with the 4th frame only.
- Four frames of raw 200 → samples clamp to 31; final temperature = 31, never wraps.
- Start a frame, then pulse sensor_start after 4 bits → sensor_err high for 1 cycle; the restarted frame of 18 completes normally; the aborted data never enters the average.
- No frames for TIMEOUT cycles → stale = 1 at cycle TIMEOUT with temperature held; the next frame clears stale on its UPDATE edge.
- Assert rst mid-SHIFT → next cycle temperature = 20, temp_valid = 0, FSM = IDLE; a following frame of 30 gives (30+60)/4 = 22.
- Frames 10, 10, 10, 10 then 28, 28, 28, 28 → temperature steps 17, 15, 12, 10, 14, 19, 23, 28; check each value visible the cycle after UPDATE.
